alu_exec: RTL and testbench

Execute-stage ALU for the MIPS32 pipeline: the consumer of the 4-bit ALU control code that the ALU control decoder produces. Accepts an operation code and two 32-bit operands through a valid/ready handshake and returns a registered result with zero and overflow flags. Single-cycle ops complete in one cycle. An optional iterative multiplier holds the unit busy until its result is ready, so the pipeline must stall through `in_ready`.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_mult_seq.sv | 50 +++++
 rtl/alu_exec.sv | 126 ++++++++++++
 tb/tb_alu_exec.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, default width and execute FSM states.
// Codes are shared with the ALU control decoder.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_MUL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MULT = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_mult_seq.sv
// alu_mult_seq: iterative shift-add multiplier, one partial product per cycle.
// Produces the low WIDTH bits, which are identical for signed and unsigned.
module alu_mult_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_run,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_addend;

    assign w_addend  = r_mplier[0] ? r_mcand : '0;
    // Sum including the current step, so the last step is usable on done
    assign o_product = r_acc + w_addend;
    assign o_done    = i_run && (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_run) begin
            r_acc    <= o_product;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with valid/ready handshake and registered flags.
// Define ALU_MULT_EN to add the iterative multiplier (code 0011).
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy
);

    alu_state_t       r_state;
    alu_state_t       w_state_nxt;
    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_prod;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ovf;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;
    logic             r_out_valid;

    assign busy      = (r_state == S_MULT);
    assign in_ready  = !busy && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_ovf;

`ifdef ALU_MULT_EN
    assign w_is_mul = (alu_ctrl == ALU_MUL);

    alu_mult_seq #(
        .WIDTH(WIDTH)
    ) u_mult (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_accept && w_is_mul),
        .i_run    (busy),
        .i_a      (src_a),
        .i_b      (src_b),
        .o_done   (w_mul_done),
        .o_product(w_mul_prod)
    );
`else
    assign w_is_mul   = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_mul_prod = '0;
`endif

    assign w_sum  = src_a + src_b;
    assign w_diff = src_a - src_b;

    // Unknown codes fall through to add, matching the decoder default
    always_comb begin
        w_alu_res = w_sum;
        w_alu_ovf = 1'b0;
        unique case (alu_ctrl)
            ALU_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1])
                         && (w_diff[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_AND: w_alu_res = src_a & src_b;
            ALU_OR:  w_alu_res = src_a | src_b;
            ALU_SLT: w_alu_res = {{(WIDTH-1){1'b0}},
                                  ($signed(src_a) < $signed(src_b))};
            default: begin
                w_alu_res = w_sum;
                w_alu_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1])
                         && (w_sum[WIDTH-1] != src_a[WIDTH-1]);
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept && w_is_mul) w_state_nxt = S_MULT;
            S_MULT: if (w_mul_done) w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_result    <= w_alu_res;
            r_zero      <= (w_alu_res == '0);
            r_ovf       <= w_alu_ovf;
            r_out_valid <= 1'b1;
        end else if (w_mul_done) begin
            r_result    <= w_mul_prod;
            r_zero      <= (w_mul_prod == '0);
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: self-checking bench for alu_exec against an arithmetic model.
// Multiplier scenarios are compiled in when ALU_MULT_EN is defined.
`timescale 1ns/1ps
module tb_alu_exec;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    alu_ctrl;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          zero;
    logic          overflow;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_exec #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_ctrl (alu_ctrl),
        .src_a    (src_a),
        .src_b    (src_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .busy     (busy)
    );

    // Reference: widen to 64-bit signed and apply the arithmetic directly
    function automatic void model(input logic [3:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] res,
                                  output logic ovf);
        longint sa, sb, s;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = 1'b0;
        case (op)
            4'b0110: begin
                s   = sa - sb;
                res = s[31:0];
                ovf = (s != longint'(int'(s[31:0])));
            end
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0111: res = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_MULT_EN
            4'b0011: begin
                s   = sa * sb;
                res = s[31:0];
            end
`endif
            default: begin
                s   = sa + sb;
                res = s[31:0];
                ovf = (s != longint'(int'(s[31:0])));
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_ctrl  = 4'b0010;
        src_a     = '0;
        src_b     = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        n_tests++;
        if (result !== 32'h0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_result got %h z=%b want 0 z=1", result, zero);
        end
        n_tests++;
        if (overflow !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got ovf=%b busy=%b want 0 0",
                     overflow, busy);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_idle got v=%b r=%h want 0 0", out_valid, result);
        end
    endtask

    task automatic test_directed();
        logic [3:0]  t_op  [6] = '{4'b0010, 4'b0110, 4'b0111,
                                   4'b0111, 4'b1111, 4'b0110};
        logic [31:0] t_a   [6] = '{32'h7FFF_FFFF, 32'd5, 32'h8000_0000,
                                   32'd1, 32'd3, 32'h8000_0000};
        logic [31:0] t_b   [6] = '{32'd1, 32'd5, 32'd1,
                                   32'h8000_0000, 32'd4, 32'd1};
        logic [31:0] t_res [6] = '{32'h8000_0000, 32'd0, 32'd1,
                                   32'd0, 32'd7, 32'h7FFF_FFFF};
        logic        t_ovf [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            alu_ctrl = t_op[i];
            src_a    = t_a[i];
            src_b    = t_b[i];
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || result !== t_res[i]
                || overflow !== t_ovf[i] || zero !== (t_res[i] == 0)) begin
                n_fail++;
                $display("FAIL directed[%0d] got v=%b r=%h o=%b z=%b want r=%h o=%b",
                         i, out_valid, result, overflow, zero, t_res[i], t_ovf[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL directed_drain got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  t_op  [3] = '{4'b0010, 4'b0001, 4'b0000};
        logic [31:0] t_a   [3] = '{32'd10, 32'h0000_00F0, 32'h0000_FF00};
        logic [31:0] t_b   [3] = '{32'd20, 32'h0000_000F, 32'h0000_0FF0};
        logic [31:0] t_res [3] = '{32'd30, 32'h0000_00FF, 32'h0000_0F00};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            alu_ctrl = t_op[i];
            src_a    = t_a[i];
            src_b    = t_b[i];
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || result !== t_res[i]) begin
                n_fail++;
                $display("FAIL b2b[%0d] got v=%b r=%h want v=1 r=%h",
                         i, out_valid, result, t_res[i]);
            end
        end
        out_ready = 1'b0;
        alu_ctrl  = 4'b0110;
        src_a     = 32'd100;
        src_b     = 32'd1;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_in_ready got %b want 0", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || result !== 32'h0000_0F00) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] got v=%b r=%h want v=1 r=00000f00",
                         i, out_valid, result);
            end
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_in_ready got %b want 1", in_ready);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || result !== 32'd99) begin
            n_fail++;
            $display("FAIL release_op got v=%b r=%h want v=1 r=00000063",
                     out_valid, result);
        end
        in_valid = 1'b0;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release_drain got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_random_handshake();
        logic        exp_valid = 1'b0;
        logic [31:0] exp_res   = '0;
        logic        exp_ovf   = 1'b0;
        logic [31:0] m_res;
        logic        m_ovf;
        logic        exp_rdy;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            alu_ctrl  = 4'($urandom_range(0, 15));
`ifdef ALU_MULT_EN
            if (alu_ctrl == 4'b0011) alu_ctrl = 4'b0010;
`endif
            src_a = pick_operand();
            src_b = pick_operand();
            #1;
            exp_rdy = !exp_valid || out_ready;
            n_tests++;
            if (in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL rnd_in_ready[%0d] got %b want %b",
                         i, in_ready, exp_rdy);
            end
            if (in_valid && exp_rdy) begin
                model(alu_ctrl, src_a, src_b, m_res, m_ovf);
                exp_valid = 1'b1;
                exp_res   = m_res;
                exp_ovf   = m_ovf;
            end else if (out_ready) begin
                exp_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            n_tests++;
            if (out_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL rnd_valid[%0d] got %b want %b",
                         i, out_valid, exp_valid);
            end else if (exp_valid && (result !== exp_res || overflow !== exp_ovf
                         || zero !== (exp_res == 0))) begin
                n_fail++;
                $display("FAIL rnd_result[%0d] got r=%h o=%b z=%b want r=%h o=%b",
                         i, result, overflow, zero, exp_res, exp_ovf);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

`ifdef ALU_MULT_EN
    task automatic test_mul();
        logic [31:0] m_res;
        logic        m_ovf;
        logic [31:0] a, b;
        int          cycles;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alu_ctrl  = 4'b0011;
        src_a     = 32'hFFFF_FFFD;
        src_b     = 32'd7;
        tick();
        alu_ctrl = 4'b0010;
        src_a    = 32'd1;
        src_b    = 32'd1;
        for (int i = 0; i < 32; i++) begin
            n_tests++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mul_busy[%0d] got busy=%b rdy=%b v=%b want 1 0 0",
                         i, busy, in_ready, out_valid);
            end
            tick();
        end
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b1 || result !== 32'hFFFF_FFEB
            || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_done got busy=%b v=%b r=%h o=%b want 0 1 ffffffeb 0",
                     busy, out_valid, result, overflow);
        end
        in_valid = 1'b0;
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || result !== 32'hFFFF_FFEB) begin
            n_fail++;
            $display("FAIL mul_ignored got v=%b r=%h want 0 ffffffeb",
                     out_valid, result);
        end
        for (int k = 0; k < 4; k++) begin
            a        = pick_operand();
            b        = $urandom;
            in_valid = 1'b1;
            alu_ctrl = 4'b0011;
            src_a    = a;
            src_b    = b;
            tick();
            in_valid = 1'b0;
            src_a    = $urandom;
            src_b    = $urandom;
            cycles   = 0;
            while (out_valid !== 1'b1 && cycles < 40) begin
                tick();
                cycles++;
            end
            model(4'b0011, a, b, m_res, m_ovf);
            n_tests++;
            if (cycles != 32 || result !== m_res || zero !== (m_res == 0)) begin
                n_fail++;
                $display("FAIL mul_rnd[%0d] got lat=%0d r=%h want lat=32 r=%h",
                         k, cycles, result, m_res);
            end
            tick();
        end
    endtask
`endif

    task automatic test_reset_mid();
        in_valid = 1'b1;
        src_a    = 32'd123;
        src_b    = 32'd456;
`ifdef ALU_MULT_EN
        out_ready = 1'b1;
        alu_ctrl  = 4'b0011;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
`else
        out_ready = 1'b0;
        alu_ctrl  = 4'b0010;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
`endif
        reset = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 32'h0
            || zero !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid got busy=%b v=%b r=%h z=%b o=%b want 0 0 0 1 0",
                     busy, out_valid, result, zero, overflow);
        end
        repeat (2) tick();
        reset     = 1'b1;
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_ready got %b want 1", in_ready);
        end
        in_valid = 1'b1;
        alu_ctrl = 4'b0010;
        src_a    = 32'd2;
        src_b    = 32'd2;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || result !== 32'd4) begin
            n_fail++;
            $display("FAIL rst_add got v=%b r=%h want 1 00000004", out_valid, result);
        end
        in_valid = 1'b0;
        repeat (30) tick();
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 32'd4) begin
            n_fail++;
            $display("FAIL rst_no_stale got busy=%b v=%b r=%h want 0 0 00000004",
                     busy, out_valid, result);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random_handshake();
`ifdef ALU_MULT_EN
        test_mul();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
